max2bitsetseq_checker: RTL and testbench

- Receive end of the max-2-bits-set sequence interface: consumes the N-bit number stream produced by the sequence generator.
- Decodes each word into popcount and bit indices, and checks it is the correct successor in the ascending sequence of N-bit values with at most 2 bits set.
- Keeps saturating pass/error/wrap counters.
- Sits downstream of the generator as an in-system monitor; also serves as the scoreboard in its bench.

---
 rtl/max2bitseq_pkg.sv | 19 +
 rtl/max2bit_decode.sv | 54 +++++
 rtl/max2bitsetseq_checker.sv | 119 +++++++++++
 tb/tb_max2bitsetseq_checker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/max2bitseq_pkg.sv
// Shared definitions for the max-2-bits-set sequence generator and checker.
package max2bitseq_pkg;

    typedef enum logic {
        SYNC,
        LOCKED
    } state_e;

    // Number of N-bit values with at most two bits set.
    function automatic int unsigned seq_len(input int unsigned n);
        return 1 + n + (n * (n - 1)) / 2;
    endfunction

    // Largest value in the sequence; its successor is 0.
    function automatic int unsigned max_val(input int unsigned n);
        return (32'd1 << (n - 1)) + (32'd1 << (n - 2));
    endfunction

endpackage

// File: rtl/max2bit_decode.sv
// Combinational decode of one word: popcount, bit indices and sequence successor.
module max2bit_decode #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         in_num,
    output logic [1:0]           popcnt,
    output logic [$clog2(N)-1:0] hi_idx,
    output logic [$clog2(N)-1:0] lo_idx,
    output logic [N-1:0]         next_num
);

    localparam int unsigned IW = $clog2(N);

    // Count set bits, locate highest/lowest, then derive the next sequence value.
    always_comb begin
        int unsigned cnt;
        int unsigned hi;
        int unsigned lo;
        logic        found;
        cnt      = 0;
        hi       = 0;
        lo       = 0;
        found    = 1'b0;
        next_num = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (in_num[i]) begin
                cnt = cnt + 1;
                hi  = i;
                if (!found) begin
                    lo    = i;
                    found = 1'b1;
                end
            end
        end
        popcnt = (cnt >= 3) ? 2'd3 : 2'(cnt);
        hi_idx = IW'(hi);
        lo_idx = IW'(lo);
        case (popcnt)
            2'd0: next_num = N'(1);
            2'd1: next_num = (hi != 0) ? ((N'(1) << hi) | N'(1)) : N'(2);
            2'd2: begin
                if (lo + 1 < hi) begin
                    next_num = (N'(1) << hi) | (N'(1) << (lo + 1));
                end else if (hi + 1 < N) begin
                    next_num = N'(1) << (hi + 1);
                end else begin
                    next_num = '0;  // top pair wraps the sequence
                end
            end
            default: next_num = '0;
        endcase
    end

endmodule

// File: rtl/max2bitsetseq_checker.sv
// In-system monitor for the max-2-bits-set sequence: decode, check and count.
module max2bitsetseq_checker
    import max2bitseq_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [N-1:0]         in_num,
    output logic                 locked,
    output logic                 dec_valid,
    output logic [1:0]           dec_popcnt,
    output logic [$clog2(N)-1:0] dec_hi_idx,
    output logic [$clog2(N)-1:0] dec_lo_idx,
    output logic                 seq_ok,
    output logic                 seq_err,
    output logic                 wrap,
    output logic [CNT_W-1:0]     ok_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     wrap_cnt
);

    localparam int unsigned IW = $clog2(N);

    state_e         state_q, state_d;
    logic [N-1:0]   expected_q, expected_d;
    logic           ok_d, err_d, wrap_d;
    logic [1:0]     popcnt;
    logic [IW-1:0]  hi_idx, lo_idx;
    logic [N-1:0]   next_num;

    max2bit_decode #(
        .N(N)
    ) u_decode (
        .in_num  (in_num),
        .popcnt  (popcnt),
        .hi_idx  (hi_idx),
        .lo_idx  (lo_idx),
        .next_num(next_num)
    );

    assign locked = (state_q == LOCKED);

    // Next-state, expected value and pulse decisions for the current word.
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        wrap_d     = 1'b0;
        if (in_valid) begin
            case (state_q)
                SYNC: begin
                    if (in_num == '0) begin
                        state_d    = LOCKED;
                        expected_d = N'(1);
                    end
                end
                LOCKED: begin
                    if (in_num == expected_q) begin
                        ok_d       = 1'b1;
                        wrap_d     = (in_num == '0);
                        expected_d = next_num;
                    end else if (popcnt != 2'd3) begin
                        // Legal but out-of-order word: resync on it without dropping lock.
                        err_d      = 1'b1;
                        expected_d = next_num;
                    end else begin
                        err_d   = 1'b1;
                        state_d = SYNC;
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    // State, registered decode/pulse outputs and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SYNC;
            expected_q <= '0;
            dec_valid  <= 1'b0;
            dec_popcnt <= '0;
            dec_hi_idx <= '0;
            dec_lo_idx <= '0;
            seq_ok     <= 1'b0;
            seq_err    <= 1'b0;
            wrap       <= 1'b0;
            ok_cnt     <= '0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            dec_valid  <= in_valid;
            seq_ok     <= ok_d;
            seq_err    <= err_d;
            wrap       <= wrap_d;
            if (in_valid) begin
                dec_popcnt <= popcnt;
                dec_hi_idx <= hi_idx;
                dec_lo_idx <= lo_idx;
            end
            if (ok_d && (ok_cnt != '1)) begin
                ok_cnt <= ok_cnt + CNT_W'(1);
            end
            if (err_d && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (wrap_d && (wrap_cnt != '1)) begin
                wrap_cnt <= wrap_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_max2bitsetseq_checker.sv
// Self-checking bench: directed plan plus random stream against a list-based model.
module tb_max2bitsetseq_checker;
    import max2bitseq_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [N-1:0]  in_num = '0;

    logic          locked, dec_valid, seq_ok, seq_err, wrap;
    logic [1:0]    dec_popcnt;
    logic [IW-1:0] dec_hi_idx, dec_lo_idx;
    logic [15:0]   ok_cnt, err_cnt, wrap_cnt;

    logic          s_locked, s_dec_valid, s_seq_ok, s_seq_err, s_wrap;
    logic [1:0]    s_dec_popcnt;
    logic [IW-1:0] s_dec_hi_idx, s_dec_lo_idx;
    logic [1:0]    s_ok_cnt, s_err_cnt, s_wrap_cnt;

    int n_checks = 0;
    int n_errs   = 0;

    // Model state
    int seq[$];
    bit m_locked;
    int m_exp;
    int m_ok, m_err, m_wrap, m_err2;
    bit e_dv, e_ok, e_err, e_wrap;
    int e_pc, e_hi, e_lo;

    always #5 clk = ~clk;

    max2bitsetseq_checker #(
        .N(N),
        .CNT_W(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_num    (in_num),
        .locked    (locked),
        .dec_valid (dec_valid),
        .dec_popcnt(dec_popcnt),
        .dec_hi_idx(dec_hi_idx),
        .dec_lo_idx(dec_lo_idx),
        .seq_ok    (seq_ok),
        .seq_err   (seq_err),
        .wrap      (wrap),
        .ok_cnt    (ok_cnt),
        .err_cnt   (err_cnt),
        .wrap_cnt  (wrap_cnt)
    );

    max2bitsetseq_checker #(
        .N(N),
        .CNT_W(2)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_num    (in_num),
        .locked    (s_locked),
        .dec_valid (s_dec_valid),
        .dec_popcnt(s_dec_popcnt),
        .dec_hi_idx(s_dec_hi_idx),
        .dec_lo_idx(s_dec_lo_idx),
        .seq_ok    (s_seq_ok),
        .seq_err   (s_seq_err),
        .wrap      (s_wrap),
        .ok_cnt    (s_ok_cnt),
        .err_cnt   (s_err_cnt),
        .wrap_cnt  (s_wrap_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Successor is simply the following entry of the ascending legal-value list.
    function automatic int nxt(input int x);
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] == x) return seq[(i + 1) % seq.size()];
        end
        return 0;
    endfunction

    task automatic model(input bit r, input bit v, input int num);
        int pc;
        e_ok = 0; e_err = 0; e_wrap = 0; e_dv = 0;
        if (r) begin
            m_locked = 0; m_exp = 0;
            m_ok = 0; m_err = 0; m_wrap = 0; m_err2 = 0;
            return;
        end
        if (!v) return;
        pc = $countones(num);
        e_dv = 1;
        e_pc = (pc > 3) ? 3 : pc;
        e_hi = 0;
        e_lo = 0;
        for (int i = 0; i < int'(N); i++) if (num[i]) e_hi = i;
        for (int i = int'(N) - 1; i >= 0; i--) if (num[i]) e_lo = i;
        if (!m_locked) begin
            if (num == 0) begin
                m_locked = 1;
                m_exp    = 1;
            end
        end else if (num == m_exp) begin
            e_ok = 1;
            if (m_ok < 65535) m_ok++;
            if (num == 0) begin
                e_wrap = 1;
                if (m_wrap < 65535) m_wrap++;
            end
            m_exp = nxt(num);
        end else begin
            e_err = 1;
            if (m_err < 65535) m_err++;
            if (m_err2 < 3) m_err2++;
            if (pc <= 2) m_exp = nxt(num);
            else m_locked = 0;
        end
    endtask

    task automatic step(input bit r, input bit v, input int num);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_num   = N'(num);
        model(r, v, num);
        @(posedge clk);
        #1;
        check("dec_valid", dec_valid, e_dv);
        check("seq_ok", seq_ok, e_ok);
        check("seq_err", seq_err, e_err);
        check("wrap", wrap, e_wrap);
        check("locked", locked, m_locked);
        check("ok_cnt", ok_cnt, m_ok);
        check("err_cnt", err_cnt, m_err);
        check("wrap_cnt", wrap_cnt, m_wrap);
        check("sat_err_cnt", s_err_cnt, m_err2);
        if (e_dv) begin
            check("dec_popcnt", dec_popcnt, e_pc);
            check("dec_hi_idx", dec_hi_idx, e_hi);
            check("dec_lo_idx", dec_lo_idx, e_lo);
        end
    endtask

    initial begin
        int r_sel, val;
        bit r, v;
        for (int x = 0; x < (1 << N); x++) begin
            if ($countones(x) <= 2) seq.push_back(x);
        end
        check("seq_len", seq.size(), seq_len(N));
        check("max_val", seq[seq.size() - 1], max_val(N));

        // Reset state
        step(1, 0, 0);
        step(1, 1, 7);
        check("rst_popcnt", dec_popcnt, 0);
        check("rst_hi", dec_hi_idx, 0);
        check("rst_lo", dec_lo_idx, 0);

        // 1: one full period back-to-back
        foreach (seq[i]) step(0, 1, seq[i]);
        step(0, 1, 0);
        check("t1_ok_cnt", ok_cnt, 11);
        check("t1_wrap_cnt", wrap_cnt, 1);
        check("t1_err_cnt", err_cnt, 0);

        // 2: words before any 0 are decoded only
        step(1, 0, 0);
        step(0, 1, 5);
        check("t2_pc5", dec_popcnt, 2);
        check("t2_hi5", dec_hi_idx, 2);
        check("t2_lo5", dec_lo_idx, 0);
        step(0, 1, 6);
        step(0, 1, 0);
        step(0, 1, 1);
        check("t2_ok_cnt", ok_cnt, 1);

        // 3: skip 5,6,8 then resync on 9
        step(0, 1, 2);
        step(0, 1, 3);
        step(0, 1, 4);
        step(0, 1, 9);
        check("t3_err", seq_err, 1);
        step(0, 1, 10);
        check("t3_ok", seq_ok, 1);

        // 4: illegal word drops lock, 0 relocks
        step(0, 1, 7);
        check("t4_pc", dec_popcnt, 3);
        check("t4_locked", locked, 0);
        step(0, 1, 0);
        check("t4_relock", locked, 1);

        // 5: idle cycles carry garbage
        for (int i = 1; i < seq.size(); i++) begin
            step(0, 1, seq[i]);
            step(0, 0, $urandom_range(0, (1 << N) - 1));
        end

        // 6: reset mid-sequence at 6
        step(1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, seq[i]);
        step(1, 1, 6);
        check("t6_ok_cnt", ok_cnt, 0);
        check("t6_locked", locked, 0);
        step(0, 1, 0);
        step(0, 1, 1);
        step(0, 1, 2);

        // 7: saturating error counter on the narrow instance
        step(1, 0, 0);
        step(0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 6);
        check("t7_sat_err", s_err_cnt, 3);
        check("t7_err_cnt", err_cnt, 5);

        // Random stream
        for (int i = 0; i < 500; i++) begin
            r     = ($urandom_range(0, 99) == 0);
            v     = ($urandom_range(0, 3) != 0);
            r_sel = $urandom_range(0, 99);
            if (!m_locked && r_sel < 30) val = 0;
            else if (r_sel < 70) val = m_exp;
            else if (r_sel < 85) val = seq[$urandom_range(0, seq.size() - 1)];
            else val = $urandom_range(0, (1 << N) - 1);
            step(r, v, val);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
